// File: rtl/memory_writer_if.sv
// Capture-buffer bus: the stream/control inputs and the status/read-back outputs.
// The producer side (datapath or host) uses the master modport. The buffer itself uses slave.
interface memory_writer_if #(
    parameter int DATA_SIZE   = 64,
    parameter int ADDR_MODULE = 14
);
    logic                   i_start;
    logic                   i_valid;
    logic [DATA_SIZE-1:0]   i_data;
    logic [ADDR_MODULE-1:0] i_rd_addr;
    logic [DATA_SIZE-1:0]   o_rd_data;
    logic                   o_busy;
    logic                   o_done;
    logic                   o_overrun;
    logic [ADDR_MODULE-1:0] o_count;

    modport master (
        output i_start, i_valid, i_data, i_rd_addr,
        input  o_rd_data, o_busy, o_done, o_overrun, o_count
    );

    modport slave (
        input  i_start, i_valid, i_data, i_rd_addr,
        output o_rd_data, o_busy, o_done, o_overrun, o_count
    );
endinterface

// File: rtl/memory_writer.sv
// Capture buffer: records one block of DATA_DEPTH valid-qualified samples into an
// inferred single-clock RAM. The block can be read back through a registered,
// read-first random-access port that works in every state.
module memory_writer #(
    parameter int DATA_SIZE   = 64,
    parameter int DATA_DEPTH  = 10501,
    parameter int ADDR_MODULE = 14
) (
    input  logic             i_clock,
    input  logic             i_reset,
    memory_writer_if.slave   bus
);

    // Storage is rounded up to a power of two so that the index width is exact.
    // Only addresses 0..DATA_DEPTH-1 are ever written or read.
    localparam int MEM_AW    = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;
    localparam int MEM_WORDS = 1 << MEM_AW;

    localparam logic [ADDR_MODULE-1:0] LAST_ADDR = ADDR_MODULE'(DATA_DEPTH - 1);
    localparam logic [ADDR_MODULE-1:0] DEPTH_A   = ADDR_MODULE'(DATA_DEPTH);

    // Reject depths that the count register cannot represent.
    generate
        if (DATA_DEPTH < 1 || DATA_DEPTH > (1 << ADDR_MODULE) - 1) begin : g_bad_depth
            $error("memory_writer: DATA_DEPTH out of range for ADDR_MODULE");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_MODULE-1:0] count_q, count_d;
    logic                   overrun_q, overrun_d;
    logic                   wr_en;
    logic [DATA_SIZE-1:0]   rd_data_q;
    logic                   rd_in_range;

    logic [DATA_SIZE-1:0]   mem [0:MEM_WORDS-1];

    // State and counters register; reset overrides every input.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    // Next-state logic: start always (re)enters CAPTURE; the write to the last address ends it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.i_start) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (bus.i_start) begin
                    state_d = ST_CAPTURE;
                end else if (bus.i_valid && count_q == LAST_ADDR) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output/datapath logic: write enable, sample count and sticky overrun flag.
    // When start and valid arrive together, start wins and the sample is dropped.
    always_comb begin
        wr_en     = 1'b0;
        count_d   = count_q;
        overrun_d = overrun_q;
        case (state_q)
            ST_CAPTURE: begin
                if (bus.i_start) begin
                    count_d = '0;
                end else if (bus.i_valid) begin
                    wr_en   = 1'b1;
                    count_d = count_q + ADDR_MODULE'(1);
                end
            end
            default: begin
                if (bus.i_start) begin
                    count_d   = '0;
                    overrun_d = 1'b0;
                end else if (bus.i_valid) begin
                    overrun_d = 1'b1;
                end
            end
        endcase
    end

    // RAM write port: the write address is the running count, and it never reaches DATA_DEPTH.
    always_ff @(posedge i_clock) begin
        if (wr_en && !i_reset) begin
            mem[count_q[MEM_AW-1:0]] <= bus.i_data;
        end
    end

    assign rd_in_range = (bus.i_rd_addr < DEPTH_A);

    // Registered read port. It is read-first: the non-blocking write is not visible until the next cycle.
    // Addresses outside the captured block return zero.
    always_ff @(posedge i_clock) begin
        if (i_reset || !rd_in_range) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem[bus.i_rd_addr[MEM_AW-1:0]];
        end
    end

    assign bus.o_rd_data = rd_data_q;
    assign bus.o_busy    = (state_q == ST_CAPTURE);
    assign bus.o_done    = (state_q == ST_DONE);
    assign bus.o_overrun = overrun_q;
    assign bus.o_count   = count_q;

endmodule

// File: tb/tb_memory_writer.sv
// Directed bench for memory_writer with DATA_DEPTH=8. Read expectations come from a
// small memory model and are queued when a read is issued. They are popped and compared
// when the registered read data appears.
module tb_memory_writer;
    localparam int DS = 64;
    localparam int DD = 8;
    localparam int AM = 14;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    memory_writer_if #(.DATA_SIZE(DS), .ADDR_MODULE(AM)) bus();

    memory_writer #(.DATA_SIZE(DS), .DATA_DEPTH(DD), .ADDR_MODULE(AM)) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    int          total_cnt = 0;
    int          pass_cnt  = 0;
    int          fail_cnt  = 0;
    logic [63:0] exp_q[$];
    logic [63:0] model_mem [0:DD-1];
    int          model_count = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare the current read data against the oldest queued expectation.
    task automatic drain_rd(input string tag);
        if (exp_q.size() == 0) begin
            total_cnt++;
            fail_cnt++;
            $error("FAIL %s: observed 0x%0h expected <empty scoreboard>", tag, bus.o_rd_data);
        end else begin
            check(tag, bus.o_rd_data, exp_q.pop_front());
        end
    endtask

    // One accepted sample: drive for one cycle, update the model, then check the count.
    task automatic send(input logic [63:0] d);
        bus.i_valid = 1'b1;
        bus.i_data  = d;
        tick();
        bus.i_valid = 1'b0;
        model_mem[model_count] = d;
        model_count++;
        $display("sample %0d data=0x%0h count=%0d", model_count - 1, d, bus.o_count);
        check("count", {50'd0, bus.o_count}, 64'(model_count));
    endtask

    // Single read transaction with 1-cycle latency.
    task automatic rd(input int a, input string tag);
        bus.i_rd_addr = AM'(a);
        exp_q.push_back((a < DD) ? model_mem[a] : 64'd0);
        tick();
        $display("read addr=%0d data=0x%0h", a, bus.o_rd_data);
        drain_rd(tag);
        bus.i_rd_addr = AM'(DD);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},    {63'd0, bus.o_busy},    64'd0);
        check({tag, "_done"},    {63'd0, bus.o_done},    64'd0);
        check({tag, "_overrun"}, {63'd0, bus.o_overrun}, 64'd0);
        check({tag, "_count"},   {50'd0, bus.o_count},   64'd0);
        check({tag, "_rd_data"}, bus.o_rd_data,          64'd0);
    endtask

    initial begin
        rst           = 1'b1;
        bus.i_start   = 1'b0;
        bus.i_valid   = 1'b0;
        bus.i_data    = '0;
        bus.i_rd_addr = AM'(DD);

        // Reset, then sit idle.
        tick();
        tick();
        rst = 1'b0;
        repeat (5) tick();
        check_reset_outputs("reset");

        // Capture a ramp with i_valid toggling every cycle.
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        model_count = 0;
        check("start_busy", {63'd0, bus.o_busy}, 64'd1);
        check("start_count", {50'd0, bus.o_count}, 64'd0);
        for (int i = 0; i < DD; i++) begin
            send(64'h10 + 64'(i));
            check("done_edge", {63'd0, bus.o_done}, (i == DD - 1) ? 64'd1 : 64'd0);
            tick();
        end
        check("full_busy", {63'd0, bus.o_busy}, 64'd0);
        check("full_done", {63'd0, bus.o_done}, 64'd1);
        check("full_count", {50'd0, bus.o_count}, 64'(DD));
        for (int a = 0; a <= DD; a++) begin
            rd(a, "ramp_rd");
        end

        // Sample after DONE sets overrun and is not written.
        bus.i_valid = 1'b1;
        bus.i_data  = 64'hFF;
        tick();
        bus.i_valid = 1'b0;
        check("overrun_set", {63'd0, bus.o_overrun}, 64'd1);
        check("overrun_done", {63'd0, bus.o_done}, 64'd1);
        check("overrun_count", {50'd0, bus.o_count}, 64'(DD));
        rd(0, "overrun_rd0");

        // Start clears overrun and count.
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        model_count = 0;
        check("restart_overrun", {63'd0, bus.o_overrun}, 64'd0);
        check("restart_count", {50'd0, bus.o_count}, 64'd0);
        check("restart_busy", {63'd0, bus.o_busy}, 64'd1);

        // Read-first: read address 2 in the cycle that writes 0x55 there.
        send(64'h30);
        send(64'h31);
        bus.i_rd_addr = AM'(2);
        exp_q.push_back(model_mem[2]);
        send(64'h55);
        drain_rd("read_first_old");
        bus.i_rd_addr = AM'(DD);
        rd(2, "read_first_new");

        // Restart mid-capture with a sample in the same cycle; start wins.
        bus.i_start = 1'b1;
        bus.i_valid = 1'b1;
        bus.i_data  = 64'hAA;
        tick();
        bus.i_start = 1'b0;
        bus.i_valid = 1'b0;
        model_count = 0;
        check("midstart_count", {50'd0, bus.o_count}, 64'd0);
        check("midstart_busy", {63'd0, bus.o_busy}, 64'd1);
        send(64'h20);
        send(64'h21);
        rd(0, "midstart_rd0");
        rd(1, "midstart_rd1");
        rd(2, "midstart_rd2");
        rd(3, "midstart_no_aa");

        // Reset in the middle of a capture, with a sample presented in the reset cycle.
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        model_count = 0;
        for (int i = 0; i < 5; i++) begin
            send(64'h40 + 64'(i));
        end
        rst         = 1'b1;
        bus.i_valid = 1'b1;
        bus.i_data  = 64'hEE;
        tick();
        rst         = 1'b0;
        bus.i_valid = 1'b0;
        check_reset_outputs("midreset");

        // Samples without start after reset only set overrun.
        bus.i_valid = 1'b1;
        bus.i_data  = 64'h77;
        tick();
        bus.i_valid = 1'b0;
        check("post_reset_overrun", {63'd0, bus.o_overrun}, 64'd1);
        check("post_reset_busy", {63'd0, bus.o_busy}, 64'd0);
        check("post_reset_count", {50'd0, bus.o_count}, 64'd0);
        rd(4, "post_reset_rd4");
        rd(5, "post_reset_rd5");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/memory_writer.md
# memory_writer

Capture buffer that is the write-side counterpart of the reference/error sample streamer. It records a block of DATA_DEPTH samples from a valid-qualified stream, such as the adaptive gain-control output, into an inferred single-clock RAM. The captured block is then available on a registered random-access read port for comparison or host readout. It sits at the output of the datapath, alongside the sample streamer on i_clock.

## Interface
- DATA_SIZE, 64, sample width in bits
- DATA_DEPTH, 10501, number of samples per capture; must satisfy 1 <= DATA_DEPTH <= 2^ADDR_MODULE - 1
- ADDR_MODULE, 14, address and count width
- i_clock  in  1  system clock, all logic on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_start  in  1  arm/restart capture (single-cycle pulse, level also accepted)
- i_valid  in  1  i_data holds a sample this cycle
- i_data  in  DATA_SIZE  sample
- i_rd_addr  in  ADDR_MODULE  read address
- o_rd_data  out  DATA_SIZE  registered read data
- o_busy  out  1  high in CAPTURE
- o_done  out  1  high in DONE (full block captured)
- o_overrun  out  1  sticky: valid sample arrived while not capturing
- o_count  out  ADDR_MODULE  samples written since last start

## Operation
- FSM states: IDLE, CAPTURE, DONE. Reset enters IDLE.
- IDLE or DONE with i_start=1: go to CAPTURE. Clear write address, o_count and o_overrun.
- CAPTURE with i_start=1: restart. Write address and o_count go to 0, state stays CAPTURE. The sample presented in that cycle is not written (i_start has priority over i_valid).
- CAPTURE with i_valid=1 and i_start=0: write i_data at address o_count, then increment o_count.
  - If the write uses address DATA_DEPTH-1, go to DONE.
  - Addresses used are exactly 0..DATA_DEPTH-1. The write address never reaches DATA_DEPTH and never wraps.
- CAPTURE with i_valid=0: hold. Gaps of any length are allowed.
- IDLE/DONE with i_valid=1 and i_start=0: no write, set o_overrun. o_overrun stays set until the next i_start or reset.
- Read port works in every state.
  - o_rd_data <= RAM[i_rd_addr] when i_rd_addr < DATA_DEPTH, else 0.
  - Same-address read and write in one cycle returns the old contents (read-first).
- RAM contents are not cleared by reset or start. o_count is the only record of valid data.

## Timing
- Reset values: state IDLE, o_busy 0, o_done 0, o_overrun 0, o_count 0, o_rd_data 0.
- Reset has priority over all inputs, including mid-capture. A sample presented in a reset cycle is not written.
- Start latency: i_start at edge N gives o_busy=1 after edge N. The first sample can be accepted at edge N+1.
- A sample accepted at edge N is in RAM and reflected in o_count after edge N. A read at edge N+1 returns it at o_rd_data after edge N+1.
- The last sample at edge N gives o_busy=0, o_done=1 and o_count=DATA_DEPTH, all after edge N.
- Read latency: exactly 1 cycle, with no stall and no handshake.
- Throughput: one sample per cycle, sustained indefinitely while in CAPTURE.

## Test plan
- Reset, then idle 5 cycles: o_busy=0, o_done=0, o_overrun=0, o_count=0, o_rd_data=0.
- DATA_DEPTH=8. Pulse i_start, then send ramp data 0x10..0x17 with i_valid toggling 1,0,1,0.
  - Expect o_done=1 exactly after the 8th accepted sample, with o_count=8.
  - Reading addresses 0..7 returns 0x10..0x17 one cycle after each address.
  - Reading address 8 returns 0.
- DATA_DEPTH=8. After DONE, drive i_valid with 0xFF: o_overrun=1 and RAM[0] still reads 0x10. A following i_start clears o_overrun and o_count.
- DATA_DEPTH=8. Capture 3 samples, then assert i_start with i_valid=1 and data 0xAA in the same cycle.
  - o_count=0 and 0xAA is not written.
  - The next samples 0x20.. land at address 0.
- Assert i_reset after 5 samples: all outputs take reset values next cycle. Samples sent afterwards without i_start set o_overrun and are not written.
- Read address 2 in the same cycle as the write to address 2 of 0x55 (previous capture held 0x12): o_rd_data=0x12. The next read of address 2 returns 0x55.
